// File: rtl/cfs_md_byte_unpacker.sv
// Serialises the valid bytes of one MD transfer onto a byte-wide valid/ready stream.
// Optional error counter output enabled by defining CFS_MD_BYTE_UNPACKER_ERR_CNT_EN.
module cfs_md_byte_unpacker #(
  parameter  int ALGN_DATA_WIDTH   = 32,
  localparam int DATA_BYTES        = ALGN_DATA_WIDTH / 8,
  localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(DATA_BYTES),
  localparam int ALGN_SIZE_WIDTH   = $clog2(DATA_BYTES) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         md_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]   md_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0] md_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   md_size,
  output logic                         md_ready,
  output logic                         md_err,
  output logic                         byte_valid,
  output logic [7:0]                   byte_data,
  output logic                         byte_last,
  input  logic                         byte_ready
`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
  ,
  output logic [7:0]                   err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RESP
  } state_t;

  localparam logic [ALGN_SIZE_WIDTH:0]   MAX_SUM = (ALGN_SIZE_WIDTH+1)'(DATA_BYTES);
  localparam logic [ALGN_SIZE_WIDTH-1:0] REM_ONE = ALGN_SIZE_WIDTH'(1);
  localparam logic [ALGN_OFFSET_WIDTH-1:0] PTR_ONE = ALGN_OFFSET_WIDTH'(1);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [ALGN_DATA_WIDTH-1:0]   r_data;
  logic [ALGN_OFFSET_WIDTH-1:0] r_ptr;
  logic [ALGN_SIZE_WIDTH-1:0]   r_rem;
  logic                         r_err;
  logic                         w_err_nxt;
  logic                         w_capture;
  logic                         w_advance;
  logic                         w_illegal;
  logic                         w_last;
  logic [ALGN_SIZE_WIDTH:0]     w_sum;

  // One extra bit on the sum so offset+size can never wrap back into range.
  assign w_sum     = (ALGN_SIZE_WIDTH+1)'(md_offset) + (ALGN_SIZE_WIDTH+1)'(md_size);
  assign w_illegal = (md_size == '0) || (w_sum > MAX_SUM);
  assign w_last    = (r_rem == REM_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_valid) begin
          if (w_illegal) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_SEND;
            w_err_nxt   = 1'b0;
            w_capture   = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (byte_ready) begin
          if (w_last) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b0;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_ptr <= md_offset;
        r_rem <= md_size;
      end else if (w_advance) begin
        r_ptr <= r_ptr + PTR_ONE;
        r_rem <= r_rem - REM_ONE;
      end
    end
  end

  // Payload register carries no reset; it is only observed while in SEND.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_data <= md_data;
    end
  end

  assign md_ready   = (r_state == ST_RESP);
  assign md_err     = (r_state == ST_RESP) && r_err;
  assign byte_valid = (r_state == ST_SEND);
  assign byte_last  = (r_state == ST_SEND) && w_last;
  assign byte_data  = (r_state == ST_SEND) ? r_data[{r_ptr, 3'b000} +: 8] : 8'h00;

`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'h00;
    end else if ((r_state == ST_RESP) && r_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_cfs_md_byte_unpacker.sv
// Directed bench for cfs_md_byte_unpacker: vector table plus backpressure, reset and
// error-counter sequences (counter section active when CFS_MD_BYTE_UNPACKER_ERR_CNT_EN is defined).
module tb_cfs_md_byte_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [31:0] md_data;
  logic [1:0]  md_offset;
  logic [2:0]  md_size;
  logic        md_ready;
  logic        md_err;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfs_md_byte_unpacker #(.ALGN_DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_valid   (md_valid),
    .md_data    (md_data),
    .md_offset  (md_offset),
    .md_size    (md_size),
    .md_ready   (md_ready),
    .md_err     (md_err),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready)
`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0]     data;
    logic [1:0]      off;
    logic [2:0]      size;
    logic            err;
    int              n;
    logic [3:0][7:0] eb;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".md_ready"}, 32'(md_ready), 0);
    chk({nm, ".md_err"}, 32'(md_err), 0);
    chk({nm, ".byte_valid"}, 32'(byte_valid), 0);
    chk({nm, ".byte_data"}, 32'(byte_data), 0);
    chk({nm, ".byte_last"}, 32'(byte_last), 0);
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns in the same position, DUT in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    md_data   = v.data;
    md_offset = v.off;
    md_size   = v.size;
    md_valid  = 1'b1;
    chk({nm, ".pre_valid"}, 32'(byte_valid), 0);
    @(posedge clk); #1;
    md_valid  = 1'b0;
    md_data   = 32'hDEADBEEF;
    md_offset = 2'd0;
    md_size   = 3'd7;
    if (v.err) begin
      chk({nm, ".err_ready"}, 32'(md_ready), 1);
      chk({nm, ".err_err"}, 32'(md_err), 1);
      chk({nm, ".err_bvalid"}, 32'(byte_valid), 0);
    end else begin
      for (int k = 0; k < v.n; k++) begin
        chk({nm, ".bvalid"}, 32'(byte_valid), 1);
        chk({nm, ".bdata"}, 32'(byte_data), 32'(v.eb[k]));
        chk({nm, ".blast"}, 32'(byte_last), (k == v.n - 1) ? 1 : 0);
        chk({nm, ".early_ready"}, 32'(md_ready), 0);
        @(posedge clk); #1;
      end
      chk({nm, ".ok_ready"}, 32'(md_ready), 1);
      chk({nm, ".ok_err"}, 32'(md_err), 0);
      chk({nm, ".ok_bvalid"}, 32'(byte_valid), 0);
      chk({nm, ".ok_bdata"}, 32'(byte_data), 0);
    end
    @(posedge clk); #1;
    chk({nm, ".ready_one_cycle"}, 32'(md_ready), 0);
  endtask

  logic [7:0] bp_rdy  [7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [7:0] bp_data [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44};
  logic [7:0] bp_last [7] = '{0, 0, 0, 0, 0, 1, 1};

  initial begin
    vec_t bad;
    vec_t one;

    tv[0]  = '{32'h44332211, 2'd1, 3'd2, 1'b0, 2, {8'h00, 8'h00, 8'h33, 8'h22}};
    tv[1]  = '{32'h44332211, 2'd0, 3'd0, 1'b1, 0, '0};
    tv[2]  = '{32'h44332211, 2'd3, 3'd2, 1'b1, 0, '0};
    tv[3]  = '{32'h44332211, 2'd3, 3'd1, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h44}};
    tv[4]  = '{32'hA1B2C3D4, 2'd0, 3'd4, 1'b0, 4, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    tv[5]  = '{32'hA1B2C3D4, 2'd2, 3'd2, 1'b0, 2, {8'h00, 8'h00, 8'hA1, 8'hB2}};
    tv[6]  = '{32'h44332211, 2'd1, 3'd3, 1'b0, 3, {8'h00, 8'h44, 8'h33, 8'h22}};
    tv[7]  = '{32'h44332211, 2'd2, 3'd3, 1'b1, 0, '0};
    tv[8]  = '{32'h44332211, 2'd0, 3'd7, 1'b1, 0, '0};
    tv[9]  = '{32'h44332211, 2'd3, 3'd7, 1'b1, 0, '0};
    tv[10] = '{32'h44332211, 2'd1, 3'd4, 1'b1, 0, '0};
    tv[11] = '{32'h000000FF, 2'd0, 3'd1, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'hFF}};
    bad    = '{32'h0, 2'd0, 3'd0, 1'b1, 0, '0};
    one    = '{32'h44332211, 2'd0, 3'd1, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'h11}};

    reset      = 1'b1;
    md_valid   = 1'b0;
    md_data    = '0;
    md_offset  = '0;
    md_size    = '0;
    byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
    chk("reset.err_cnt", 32'(err_cnt), 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_vec(tv[i], $sformatf("vec%0d", i));
    end

    // Backpressure: size-4 transfer with ready pattern 1,0,0,1,1,0,1.
    md_data   = 32'h44332211;
    md_offset = 2'd0;
    md_size   = 3'd4;
    md_valid  = 1'b1;
    @(posedge clk); #1;
    md_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      byte_ready = bp_rdy[i][0];
      chk($sformatf("bp%0d.bvalid", i), 32'(byte_valid), 1);
      chk($sformatf("bp%0d.bdata", i), 32'(byte_data), 32'(bp_data[i]));
      chk($sformatf("bp%0d.blast", i), 32'(byte_last), 32'(bp_last[i]));
      chk($sformatf("bp%0d.md_ready", i), 32'(md_ready), 0);
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
    chk("bp.md_ready", 32'(md_ready), 1);
    chk("bp.md_err", 32'(md_err), 0);
    chk("bp.bvalid_after", 32'(byte_valid), 0);
    @(posedge clk); #1;

    // Reset after two bytes of a size-4 transfer.
    md_data   = 32'h44332211;
    md_offset = 2'd0;
    md_size   = 3'd4;
    md_valid  = 1'b1;
    @(posedge clk); #1;
    md_valid = 1'b0;
    chk("mr.byte0", 32'(byte_data), 32'h11);
    @(posedge clk); #1;
    chk("mr.byte1", 32'(byte_data), 32'h22);
    @(posedge clk); #1;
    chk("mr.byte2", 32'(byte_data), 32'h33);
    reset = 1'b1;
    #1;
    chk_idle_outputs("mr.async");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mr.no_resp%0d", i), 32'(md_ready), 0);
      chk($sformatf("mr.no_byte%0d", i), 32'(byte_valid), 0);
      @(posedge clk); #1;
    end
    run_vec(one, "mr.after");

`ifdef CFS_MD_BYTE_UNPACKER_ERR_CNT_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ec.start", 32'(err_cnt), 0);
    for (int i = 0; i < 3; i++) run_vec(bad, "ec.bad");
    chk("ec.three", 32'(err_cnt), 3);
    run_vec(one, "ec.good");
    chk("ec.good_no_inc", 32'(err_cnt), 3);
    for (int i = 0; i < 257; i++) run_vec(bad, "ec.sat");
    chk("ec.saturate", 32'(err_cnt), 255);
    reset = 1'b1;
    #1;
    chk("ec.reset", 32'(err_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
